// File: rtl/dco_freq_meter_if.sv
// Purpose : request/result bundle of the DCO frequency meter.
// Ports   : start/win_len (requester -> meter); busy/count/valid/ovf (meter -> requester).
// Modports: master = requester side, slave = meter side.
interface dco_freq_meter_if #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 16
);
   logic             start;
   logic [WIN_W-1:0] win_len;
   logic             busy;
   logic [CNT_W-1:0] count;
   logic             valid;
   logic             ovf;

   modport master (output start, win_len, input busy, count, valid, ovf);
   modport slave  (input start, win_len, output busy, count, valid, ovf);
endinterface

// File: rtl/dco_freq_meter.sv
// Purpose : counts synchronised rising edges of async i_osc_in over a window of win_len clk cycles.
// Latency : result valid one-cycle pulse at T+win_len+1 for start at T; osc edge -> counted after SYNC_STAGES+1.
// Backpr. : none; start is ignored while busy or in the DONE cycle (not queued).
// Ports   : i_clk, i_rst (sync, active-high), i_osc_in (async DCO output), bus (dco_freq_meter_if.slave).
// Option  : FMETER_CONTINUOUS_EN -- when defined, DONE re-arms a new window while win_len != 0.
module dco_freq_meter #(
   parameter int CNT_W       = 16,
   parameter int WIN_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_osc_in,
   dco_freq_meter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic [WIN_W-1:0]       r_win_cnt;
   logic [CNT_W-1:0]       r_edge_cnt;
   logic                   r_ovf_pend;
   logic                   r_busy;
   logic                   r_valid;
   logic                   r_ovf;
   logic [CNT_W-1:0]       r_count;

   logic                   w_edge;
   logic [CNT_W:0]         w_sum;
   logic                   w_sat;
   logic [CNT_W-1:0]       w_next;
   logic                   w_last;
   logic                   w_win_nz;
   logic                   w_load;

   // Rising edge seen on the synchronised signal, one cycle after the last sync flop.
   assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_hist;

   // Extra carry bit detects wrap; the counter then sticks at all-ones.
   assign w_sum    = {1'b0, r_edge_cnt} + {{CNT_W{1'b0}}, w_edge};
   assign w_sat    = w_sum[CNT_W];
   assign w_next   = w_sat ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   assign w_last   = (r_win_cnt == WIN_W'(1));
   assign w_win_nz = (bus.win_len != '0);

`ifdef FMETER_CONTINUOUS_EN
   // Free-running: DONE re-arms with the current win_len; win_len==0 stops it.
   assign w_load = w_win_nz & (((r_state == IDLE) & bus.start) | (r_state == DONE));
`else
   assign w_load = w_win_nz & (r_state == IDLE) & bus.start;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_sync     <= '0;
         r_hist     <= 1'b0;
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_ovf_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
         r_count    <= '0;
      end else begin
         // Synchroniser and history flop run in every state.
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_osc_in};
         r_hist  <= r_sync[SYNC_STAGES-1];
         r_valid <= 1'b0;

         if (w_load) begin
            r_win_cnt  <= bus.win_len;
            r_edge_cnt <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MEASURE;
         end else begin
            case (r_state)
               IDLE: begin
                  r_busy <= 1'b0;
               end
               MEASURE: begin
                  r_win_cnt  <= r_win_cnt - WIN_W'(1);
                  r_edge_cnt <= w_next;
                  if (w_sat) r_ovf_pend <= 1'b1;
                  // Final window cycle: fold in this cycle's edge directly into the result.
                  if (w_last) begin
                     r_count <= w_next;
                     r_ovf   <= r_ovf_pend | w_sat;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= DONE;
                  end
               end
               DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy  = r_busy;
   assign bus.count = r_count;
   assign bus.valid = r_valid;
   assign bus.ovf   = r_ovf;

endmodule
